// File: rtl/cpu_bus_responder.sv
// ---------------------------------------------------------------------------
// cpu_bus_responder
//
// Bridges a 65816-style CPU bus, sampled on phi2 edge strobes in the 12 MHz
// domain, onto a simple request/acknowledge memory port.
// - phi2 rise with a valid address latches {bank, address} and direction.
// - Reads request immediately. Writes request after the write data is
//   captured at phi2 fall.
// - Read data is driven to the CPU from completion until the clock after
//   the next phi2 fall.
// - A 4-bit saturating wait counter force-completes a stalled transaction
//   after ACK_TIMEOUT clocks. A forced read returns 8'hFF.
//
// Configuration macro: BUS_WAIT_STATE_EN
//   defined   : a phi2 fall while a read is still pending pulls RDY low until
//               the data is presented. The data is then held to the next fall.
//   undefined : RDY is tied high. A phi2 fall while a read is pending
//               abandons the read, and any late ack is ignored.
//
// Ports
//   i_Clk_12MHz, i_Reset          clock, async active-high reset
//   i_Phi_Rise, i_Phi_Fall        one-clock phi2 edge strobes
//   i_Addr[15:0], i_Data[7:0]     CPU address / multiplexed bank+data bus
//   i_RWB, i_VDA, i_VPA           CPU cycle qualifiers
//   o_Data[7:0], o_Data_Oe        read data and bus drive enable to CPU
//   o_Cpu_Rdy                     CPU RDY
//   o_Mem_Addr[23:0]              latched {bank, address}
//   o_Mem_Rd, o_Mem_Wr            one-clock memory request pulses
//   o_Mem_Wdata[7:0]              captured write data
//   i_Mem_Rdata[7:0], i_Mem_Ack   memory read data / completion
// ---------------------------------------------------------------------------
module cpu_bus_responder #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        i_Clk_12MHz,
  input  logic        i_Reset,
  input  logic        i_Phi_Rise,
  input  logic        i_Phi_Fall,
  input  logic [15:0] i_Addr,
  input  logic [7:0]  i_Data,
  input  logic        i_RWB,
  input  logic        i_VDA,
  input  logic        i_VPA,
  output logic [7:0]  o_Data,
  output logic        o_Data_Oe,
  output logic        o_Cpu_Rdy,
  output logic [23:0] o_Mem_Addr,
  output logic        o_Mem_Rd,
  output logic        o_Mem_Wr,
  output logic [7:0]  o_Mem_Wdata,
  input  logic [7:0]  i_Mem_Rdata,
  input  logic        i_Mem_Ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WCAP = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  // The count is the number of WAIT clocks already spent. Completion fires
  // on the clock where this count equals ACK_TIMEOUT-1, which is the
  // ACK_TIMEOUT-th WAIT clock.
  localparam logic [3:0] TIMEOUT_LAST = 4'(ACK_TIMEOUT - 1);

  state_t      state_q;
  logic        is_read_q;
  logic [3:0]  wait_cnt_q;
  logic [3:0]  wait_cnt_d;
  logic        timeout_d;
  logic        done_d;
  logic [7:0]  data_q;
  logic        data_oe_q;
  logic [23:0] mem_addr_q;
  logic        mem_rd_q;
  logic        mem_wr_q;
  logic [7:0]  mem_wdata_q;

  // Saturating wait-count increment and the completion condition for WAIT.
  always_comb begin
    wait_cnt_d = 4'd0;
    if (wait_cnt_q == 4'hF) begin
      wait_cnt_d = 4'hF;
    end else begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
    timeout_d = (wait_cnt_q == TIMEOUT_LAST);
    done_d    = i_Mem_Ack | timeout_d;
  end

`ifdef BUS_WAIT_STATE_EN
  logic rdy_q;
`endif

  // Bus-cycle FSM. It also owns every registered output.
  always_ff @(posedge i_Clk_12MHz or posedge i_Reset) begin
    if (i_Reset) begin
      state_q     <= IDLE;
      is_read_q   <= 1'b0;
      wait_cnt_q  <= 4'd0;
      data_q      <= 8'h00;
      data_oe_q   <= 1'b0;
      mem_addr_q  <= 24'h000000;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= 8'h00;
`ifdef BUS_WAIT_STATE_EN
      rdy_q       <= 1'b1;
`endif
    end else begin
      // Request strobes are single-clock pulses.
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_Phi_Rise && (i_VDA || i_VPA)) begin
            // While phi2 is low, the data bus carries the bank byte.
            mem_addr_q <= {i_Data, i_Addr};
            is_read_q  <= i_RWB;
            wait_cnt_q <= 4'd0;
            if (i_RWB) begin
              mem_rd_q <= 1'b1;
              state_q  <= WAIT;
            end else begin
              state_q  <= WCAP;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        WCAP: begin
          // Write data is valid on the bus at the end of phi2 high.
          if (i_Phi_Fall) begin
            mem_wdata_q <= i_Data;
            mem_wr_q    <= 1'b1;
            wait_cnt_q  <= 4'd0;
            state_q     <= WAIT;
          end else begin
            state_q <= WCAP;
          end
        end
        WAIT: begin
          // A completion takes priority over a phi2 fall in the same clock.
          if (done_d) begin
            if (is_read_q) begin
              data_q    <= i_Mem_Ack ? i_Mem_Rdata : 8'hFF;
              data_oe_q <= 1'b1;
`ifdef BUS_WAIT_STATE_EN
              rdy_q     <= 1'b1;
`endif
              state_q   <= HOLD;
            end else begin
              state_q <= IDLE;
            end
          end else if (is_read_q && i_Phi_Fall) begin
`ifdef BUS_WAIT_STATE_EN
            // Stretch the CPU cycle until the memory answers.
            rdy_q      <= 1'b0;
            wait_cnt_q <= wait_cnt_d;
`else
            // The CPU has closed its cycle, so drop the read.
            state_q    <= IDLE;
`endif
          end else begin
            wait_cnt_q <= wait_cnt_d;
          end
        end
        HOLD: begin
          // Drive through the fall clock and release one clock later.
          if (i_Phi_Fall) begin
            data_oe_q <= 1'b0;
            state_q   <= IDLE;
          end else begin
            state_q <= HOLD;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_Data      = data_q;
  assign o_Data_Oe   = data_oe_q;
  assign o_Mem_Addr  = mem_addr_q;
  assign o_Mem_Rd    = mem_rd_q;
  assign o_Mem_Wr    = mem_wr_q;
  assign o_Mem_Wdata = mem_wdata_q;
`ifdef BUS_WAIT_STATE_EN
  assign o_Cpu_Rdy   = rdy_q;
`else
  assign o_Cpu_Rdy   = 1'b1;
`endif

endmodule

// File: tb/tb_cpu_bus_responder.sv
// ---------------------------------------------------------------------------
// Testbench for cpu_bus_responder.
// Stimulus is a per-cycle table built from transaction descriptions.
// For each transaction, the same description is turned into per-cycle
// expected outputs with cycle arithmetic:
// - a request appears one clock after its strobe;
// - a completion happens at the earlier of the ack and the timeout;
// - the data drive lasts until the clock after the relevant fall.
// A compare process checks every output on every cycle. A few literal
// expectations pin particular cycles.
// ---------------------------------------------------------------------------
module tb_cpu_bus_responder;

  localparam int N      = 300;
  localparam int ACK_TO = 15;

  logic        clk = 1'b0;
  logic        i_Reset;
  logic        i_Phi_Rise, i_Phi_Fall;
  logic [15:0] i_Addr;
  logic [7:0]  i_Data;
  logic        i_RWB, i_VDA, i_VPA;
  logic [7:0]  o_Data;
  logic        o_Data_Oe, o_Cpu_Rdy;
  logic [23:0] o_Mem_Addr;
  logic        o_Mem_Rd, o_Mem_Wr;
  logic [7:0]  o_Mem_Wdata;
  logic [7:0]  i_Mem_Rdata;
  logic        i_Mem_Ack;

  cpu_bus_responder #(.ACK_TIMEOUT(ACK_TO)) dut (
    .i_Clk_12MHz(clk), .i_Reset(i_Reset),
    .i_Phi_Rise(i_Phi_Rise), .i_Phi_Fall(i_Phi_Fall),
    .i_Addr(i_Addr), .i_Data(i_Data), .i_RWB(i_RWB),
    .i_VDA(i_VDA), .i_VPA(i_VPA),
    .o_Data(o_Data), .o_Data_Oe(o_Data_Oe), .o_Cpu_Rdy(o_Cpu_Rdy),
    .o_Mem_Addr(o_Mem_Addr), .o_Mem_Rd(o_Mem_Rd), .o_Mem_Wr(o_Mem_Wr),
    .o_Mem_Wdata(o_Mem_Wdata), .i_Mem_Rdata(i_Mem_Rdata), .i_Mem_Ack(i_Mem_Ack)
  );

  always #5 clk = ~clk;

  // Stimulus table
  logic        s_rst [N];
  logic        s_rise [N];
  logic        s_fall [N];
  logic        s_vda [N];
  logic        s_vpa [N];
  logic        s_rwb [N];
  logic        s_ack [N];
  logic [15:0] s_addr [N];
  logic [7:0]  s_dat [N];
  logic [7:0]  s_rdata [N];
  // Expected outputs per cycle
  logic        e_rd [N];
  logic        e_wr [N];
  logic        e_oe [N];
  logic        e_rdy [N];
  logic [23:0] e_addr [N];
  logic [7:0]  e_wdata [N];
  logic [7:0]  e_data [N];

  int n_checks = 0;
  int n_errors = 0;

  function automatic void hold_addr(int k, logic [23:0] v);
    for (int i = k; i < N; i++) e_addr[i] = v;
  endfunction

  function automatic void hold_wdata(int k, logic [7:0] v);
    for (int i = k; i < N; i++) e_wdata[i] = v;
  endfunction

  function automatic void hold_data(int k, logic [7:0] v);
    for (int i = k; i < N; i++) e_data[i] = v;
  endfunction

  // Read cycle:
  // - r      : rise strobe cycle.
  // - ack    : ack cycle, or -1 for no ack.
  // - f      : phi2 fall cycle, or -1 when a reset cuts the read short.
  // - f2     : the following fall.
  function automatic void sched_read(int r, logic [7:0] bank, logic [15:0] a,
                                     logic vda, logic vpa, int ack,
                                     logic [7:0] rdat, int f, int f2);
    int c;
    int last;
    logic complete;
    logic [7:0] v;
    s_rise[r] = 1'b1; s_dat[r] = bank; s_addr[r] = a;
    s_vda[r] = vda; s_vpa[r] = vpa; s_rwb[r] = 1'b1;
    if (ack >= 0) begin s_ack[ack] = 1'b1; s_rdata[ack] = rdat; end
    if (f >= 0) s_fall[f] = 1'b1;
    if (f2 >= 0) s_fall[f2] = 1'b1;
    hold_addr(r + 1, {bank, a});
    e_rd[r + 1] = 1'b1;
    if (f < 0) return;
    // Completion is the earlier of the ack and the ACK_TO-th WAIT clock.
    c = (ack >= 0 && ack < r + ACK_TO) ? ack : r + ACK_TO;
    v = (c == ack) ? rdat : 8'hFF;
    last = (f > c) ? f : f2;
`ifdef BUS_WAIT_STATE_EN
    complete = 1'b1;
    if (f < c) for (int i = f + 1; i <= c; i++) e_rdy[i] = 1'b0;
`else
    complete = (f >= c);
`endif
    if (complete) begin
      hold_data(c + 1, v);
      for (int i = c + 1; i <= last; i++) e_oe[i] = 1'b1;
    end
  endfunction

  // Write cycle: rise at r, data at fall f, request pulse one clock after f.
  function automatic void sched_write(int r, logic [7:0] bank, logic [15:0] a,
                                      int f, logic [7:0] wd, int ack);
    s_rise[r] = 1'b1; s_dat[r] = bank; s_addr[r] = a;
    s_vda[r] = 1'b1; s_rwb[r] = 1'b0;
    s_fall[f] = 1'b1; s_dat[f] = wd;
    if (ack >= 0) s_ack[ack] = 1'b1;
    hold_addr(r + 1, {bank, a});
    hold_wdata(f + 1, wd);
    e_wr[f + 1] = 1'b1;
  endfunction

  // Reset held for cycles k..m-1; everything from k returns to reset values.
  function automatic void apply_reset(int k, int m);
    for (int i = k; i < m; i++) s_rst[i] = 1'b1;
    for (int i = k; i < N; i++) begin
      e_rd[i] = 1'b0; e_wr[i] = 1'b0; e_oe[i] = 1'b0; e_rdy[i] = 1'b1;
    end
    hold_addr(k, 24'h000000);
    hold_wdata(k, 8'h00);
    hold_data(k, 8'h00);
  endfunction

  task automatic chk(input string name, input int k, input logic [23:0] act,
                     input logic [23:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, k, act, exp);
    end
  endtask

  // Build the tables, then drive each cycle 2 ns after its rising edge.
  initial begin
    i_Reset = 1'b1; i_Phi_Rise = 1'b0; i_Phi_Fall = 1'b0;
    i_Addr = 16'h0000; i_Data = 8'h00; i_RWB = 1'b1;
    i_VDA = 1'b0; i_VPA = 1'b0; i_Mem_Rdata = 8'h00; i_Mem_Ack = 1'b0;
    for (int i = 0; i < N; i++) begin
      s_rst[i] = 1'b0; s_rise[i] = 1'b0; s_fall[i] = 1'b0;
      s_vda[i] = 1'b0; s_vpa[i] = 1'b0; s_rwb[i] = 1'b1; s_ack[i] = 1'b0;
      s_addr[i] = 16'(i * 37); s_dat[i] = 8'(i * 11); s_rdata[i] = 8'(i * 7);
      e_rd[i] = 1'b0; e_wr[i] = 1'b0; e_oe[i] = 1'b0; e_rdy[i] = 1'b1;
      e_addr[i] = 24'h000000; e_wdata[i] = 8'h00; e_data[i] = 8'h00;
    end
    for (int i = 0; i < 3; i++) s_rst[i] = 1'b1;
    // T1 basic read, ack one clock after the request pulse.
    sched_read(10, 8'h12, 16'h3456, 1'b1, 1'b0, 12, 8'hA5, 16, -1);
    // A rise while busy must be ignored.
    s_rise[13] = 1'b1; s_vda[13] = 1'b1; s_dat[13] = 8'h77; s_addr[13] = 16'hBEEF;
    // T2 write. An ack during capture is ignored; the real ack comes at 40.
    sched_write(30, 8'h00, 16'h0010, 36, 8'h5A, 40);
    s_ack[32] = 1'b1;
    // T3 three internal-operation cycles.
    for (int j = 0; j < 3; j++) begin
      s_rise[50 + 12 * j] = 1'b1; s_fall[56 + 12 * j] = 1'b1;
      s_rwb[50 + 12 * j] = 1'(j & 1);
    end
    // T4 program fetch via VPA.
    sched_read(90, 8'h01, 16'hFFFC, 1'b0, 1'b1, 93, 8'hC3, 96, -1);
    // T5 no ack, late fall: timeout completes with FF.
    sched_read(110, 8'h02, 16'h2000, 1'b1, 1'b0, -1, 8'h00, 130, -1);
    // T6 no ack, early fall.
    sched_read(150, 8'h03, 16'h3000, 1'b1, 1'b0, -1, 8'h00, 156, 168);
    // T7 ack arrives 6 clocks after the fall.
    sched_read(180, 8'h04, 16'h4000, 1'b1, 1'b0, 192, 8'hA5, 186, 198);
    // T8 write with no ack, which times out back to idle.
    sched_write(210, 8'hAB, 16'h1234, 216, 8'h33, -1);
    // T9 reset in WAIT. T10 is a normal read afterwards.
    sched_read(240, 8'h09, 16'h1111, 1'b1, 1'b0, -1, 8'h00, -1, -1);
    apply_reset(245, 247);
    sched_read(255, 8'h55, 16'hAAAA, 1'b1, 1'b0, 258, 8'h66, 262, -1);

    for (int k = 0; k < N; k++) begin
      @(posedge clk);
      #2;
      i_Reset = s_rst[k]; i_Phi_Rise = s_rise[k]; i_Phi_Fall = s_fall[k];
      i_Addr = s_addr[k]; i_Data = s_dat[k]; i_RWB = s_rwb[k];
      i_VDA = s_vda[k]; i_VPA = s_vpa[k];
      i_Mem_Ack = s_ack[k]; i_Mem_Rdata = s_rdata[k];
    end
  end

  // Compare every output against the model every cycle, 4 ns after the edge.
  initial begin
    for (int k = 0; k < N; k++) begin
      @(posedge clk);
      #4;
      chk("mem_rd", k, 24'(o_Mem_Rd), 24'(e_rd[k]));
      chk("mem_wr", k, 24'(o_Mem_Wr), 24'(e_wr[k]));
      chk("data_oe", k, 24'(o_Data_Oe), 24'(e_oe[k]));
      chk("cpu_rdy", k, 24'(o_Cpu_Rdy), 24'(e_rdy[k]));
      chk("mem_addr", k, o_Mem_Addr, e_addr[k]);
      chk("mem_wdata", k, 24'(o_Mem_Wdata), 24'(e_wdata[k]));
      chk("data", k, 24'(o_Data), 24'(e_data[k]));
      // Hand-computed anchors.
      if (k == 11) begin
        chk("lit_t1_addr", k, o_Mem_Addr, 24'h123456);
        chk("lit_t1_rd", k, 24'(o_Mem_Rd), 24'd1);
      end
      if (k == 13) chk("lit_t1_data", k, 24'(o_Data), 24'h0000A5);
      if (k == 16) chk("lit_t1_oe_fall", k, 24'(o_Data_Oe), 24'd1);
      if (k == 17) chk("lit_t1_oe_off", k, 24'(o_Data_Oe), 24'd0);
      if (k == 37) begin
        chk("lit_t2_wr", k, 24'(o_Mem_Wr), 24'd1);
        chk("lit_t2_wdata", k, 24'(o_Mem_Wdata), 24'h00005A);
      end
      if (k == 126) chk("lit_t5_ff", k, 24'(o_Data), 24'h0000FF);
`ifdef BUS_WAIT_STATE_EN
      if (k == 160) chk("lit_t6_rdy", k, 24'(o_Cpu_Rdy), 24'd0);
      if (k == 193) chk("lit_t7_data", k, 24'(o_Data), 24'h0000A5);
`else
      if (k == 160) chk("lit_t6_oe", k, 24'(o_Data_Oe), 24'd0);
      if (k == 193) chk("lit_t7_oe", k, 24'(o_Data_Oe), 24'd0);
`endif
      if (k == 245) chk("lit_t9_addr", k, o_Mem_Addr, 24'h000000);
      if (k == 256) chk("lit_t10_addr", k, o_Mem_Addr, 24'h55AAAA);
      if (k == 259) chk("lit_t10_data", k, 24'(o_Data), 24'h000066);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpu_bus_responder.md
CPU_BUS_RESPONDER -- requirements
Module: cpu_bus_responder

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 15, meaning clocks in WAIT before a read is force-completed.
REQ-002 SHALL have port i_Clk_12MHz  in  1  sole system clock.
REQ-003 SHALL have port i_Reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port i_Phi_Rise  in  1  one-clock strobe: phi2 goes high this clock.
REQ-005 SHALL have port i_Phi_Fall  in  1  one-clock strobe: phi2 goes low this clock.
REQ-006 SHALL have port i_Addr  in  16  CPU address A15..A0.
REQ-007 SHALL have port i_Data  in  8  CPU D bus: bank during phi2 low, write data during phi2 high.
REQ-008 SHALL have port i_RWB  in  1  CPU read (1) / write (0).
REQ-009 SHALL have ports i_VDA, i_VPA  in  1 each  CPU valid data/program address.
REQ-010 SHALL have port o_Data  out  8  read data to CPU.
REQ-011 SHALL have port o_Data_Oe  out  1  CPU D bus drive enable.
REQ-012 SHALL have port o_Cpu_Rdy  out  1  CPU RDY.
REQ-013 SHALL have port o_Mem_Addr  out  24  {bank, address}.
REQ-014 SHALL have ports o_Mem_Rd, o_Mem_Wr  out  1 each  one-clock request pulses.
REQ-015 SHALL have port o_Mem_Wdata  out  8  write data.
REQ-016 SHALL have ports i_Mem_Rdata  in  8 and i_Mem_Ack  in  1  memory read data and completion.

Function
REQ-017 SHALL implement states IDLE, WCAP, WAIT, HOLD; all outputs registered.
REQ-018 In IDLE, on i_Phi_Rise with (i_VDA|i_VPA)=1, SHALL latch o_Mem_Addr <= {i_Data, i_Addr} and the direction from i_RWB.
REQ-019 In IDLE, on i_Phi_Rise with i_VDA=i_VPA=0, SHALL remain in IDLE with no memory request.
REQ-020 Read: SHALL pulse o_Mem_Rd in the clock after the latching i_Phi_Rise and enter WAIT.
REQ-021 Write: SHALL enter WCAP; on i_Phi_Fall SHALL capture i_Data into o_Mem_Wdata, pulse o_Mem_Wr next clock, enter WAIT.
REQ-022 In read WAIT, on i_Mem_Ack SHALL load o_Data <= i_Mem_Rdata, assert o_Data_Oe next clock, and enter HOLD.
REQ-023 In write WAIT, on i_Mem_Ack SHALL return to IDLE.
REQ-024 In HOLD, SHALL keep o_Data_Oe high through the i_Phi_Fall clock and clear it the clock after, then enter IDLE.
REQ-025 SHALL count clocks in WAIT (4-bit, saturating); on reaching ACK_TIMEOUT SHALL complete as if acked, with read data 8'hFF.
REQ-026 i_Mem_Ack outside WAIT SHALL be ignored; i_Phi_Rise outside IDLE SHALL be ignored.
REQ-027 Read with i_Phi_Fall in WAIT before ack: handling per REQ-031/REQ-032.
REQ-028 o_Mem_Rd and o_Mem_Wr SHALL never be high in the same clock.

Reset
REQ-029 i_Reset SHALL asynchronously force IDLE, o_Data=8'h00, o_Data_Oe=0, o_Cpu_Rdy=1, o_Mem_Addr=0, o_Mem_Rd=0, o_Mem_Wr=0, o_Mem_Wdata=0, timeout count=0.
REQ-030 Reset mid-transaction SHALL abandon it; the first cycle after release SHALL be accepted normally on the next i_Phi_Rise.

Configuration
REQ-031 With BUS_WAIT_STATE_EN defined: i_Phi_Fall in read WAIT without ack SHALL drive o_Cpu_Rdy=0 next clock, and o_Cpu_Rdy SHALL return to 1 on the clock o_Data_Oe asserts; HOLD then ends on the next i_Phi_Fall.
REQ-032 Without BUS_WAIT_STATE_EN: o_Cpu_Rdy SHALL be constant 1; i_Phi_Fall in read WAIT SHALL abort to IDLE with o_Data_Oe=0, and the late ack SHALL be ignored.

Verification
REQ-033 Read: D=8'h12, A=16'h3456, VDA=1, RWB=1, ack 1 clock after o_Mem_Rd with 8'hA5 -> o_Mem_Addr=24'h123456, single o_Mem_Rd pulse, o_Data=8'hA5, Oe high until the clock after fall.
REQ-034 Write: D=8'h00 at rise, A=16'h0010, RWB=0, D=8'h5A at fall -> o_Mem_Wdata=8'h5A, o_Mem_Wr pulsed clock after fall, no Oe.
REQ-035 Internal op: VDA=VPA=0 across 3 phi2 cycles -> no Rd/Wr pulses, Oe stays 0.
REQ-036 No ack: read, i_Mem_Ack held 0 -> after 15 WAIT clocks o_Data=8'hFF (macro off: aborted at fall, Oe never set).
REQ-037 Macro on, ack 6 clocks after fall -> o_Cpu_Rdy low from clock after fall until Oe asserts, data 8'hA5 delivered.
REQ-038 Reset asserted in WAIT -> all outputs at REQ-029 values immediately; next read completes normally.
